demux32_row: RTL and testbench
==============================

# demux32_row

Row packer for the matrix-multiply datapath, and the write-side counterpart of the 32:1 word selector. It accepts a stream of 32-bit words over a valid/ready handshake and places word k into slot k of a 1024-bit row, with slot k occupying bits [32k+31:32k]. Completed rows are held in an output register and presented over a second valid/ready handshake. A fill buffer runs in parallel with the output register, so the next row keeps filling while the previous row waits downstream.

## Interface
- `WIDTH`, default 32: word width; row width is 32*WIDTH. Only 32 is verified.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when `in_valid && in_ready`.
- `in_data`  in  32  input word.
- `in_flush`  in  1  close a partial row; unfilled slots are zero.
- `out_valid`  out  1  `out_data` holds a complete row.
- `out_ready`  in  1  consumer takes the row when `out_valid && out_ready`.
- `out_data`  out  1024  row; slot k at bits [32k+31:32k].
- `fill_cnt`  out  6  words currently held in the fill buffer (0..32).

## Operation
- State:
  - `fill_buf[1023:0]`
  - `fill_cnt[5:0]`
  - `out_data` register
  - `out_valid` flag
- Output slot is free this cycle: `slot_free = !out_valid || out_ready`.
- `in_ready = !rst && (fill_cnt != 32)`. This is combinational from registered state only; it has no path from `in_valid` or `in_data`.
- Accept (`in_valid && in_ready`) when `fill_cnt < 31`:
  - `fill_buf` slot `fill_cnt[4:0]` <= `in_data`.
  - `fill_cnt` <= `fill_cnt` + 1.
- Accept at `fill_cnt == 31`:
  - If `slot_free`: `out_data` <= `fill_buf` with slot 31 replaced by `in_data`; `out_valid` <= 1; `fill_buf` <= 0; `fill_cnt` <= 0. This is the bypass path and adds no bubble.
  - Else: write slot 31 and set `fill_cnt` <= 32 (row stalled).
- Stalled row (`fill_cnt == 32`):
  - `in_ready` = 0.
  - On the first edge where `slot_free` holds: transfer `fill_buf` to `out_data`; `out_valid` <= 1; `fill_buf` <= 0; `fill_cnt` <= 0.
- Flush: `in_flush` is honoured only when the row count after this cycle's accept lies in 1..31.
  - The row completes as if full: transfer immediately if `slot_free`, else `fill_cnt` <= 32 and stall.
  - Padding costs nothing extra, because `fill_buf` is zero in every unwritten slot (cleared at reset and at every transfer).
  - `in_flush` is ignored when `fill_cnt` is 0 or 32, or when the same-cycle accept completes the row.
- Simultaneous flush and accept: the word is written first, then the flush applies to the resulting count.
- Output pop (`out_valid && out_ready`) with no transfer on the same edge: `out_valid` <= 0. `out_data` keeps its value.
- Pop and transfer on the same edge: the new row replaces the old one and `out_valid` stays 1.
- `out_data` and `out_valid` change only on a transfer or a pop. `out_data` is stable while `out_valid && !out_ready`.

## Timing
- Reset values: `fill_buf` = 0, `fill_cnt` = 0, `out_data` = 0, `out_valid` = 0. `in_ready` = 0 while `rst` is high and 1 on the first cycle after.
- Reset mid-row or with a row pending: all data is discarded and no partial row is emitted.
- Latency: the 32nd word accepted at edge E gives `out_valid` = 1 after E when the slot is free.
- Throughput: with `out_ready` held at 1, one word per cycle is sustained, which is one row per 32 cycles with no bubble.
- Stall recovery: a stalled row transfers on the edge where `out_ready` is seen high. `in_ready` returns to 1 in the following cycle.
- Flush latency: a flush at edge E with the slot free gives `out_valid` after E.

## Test plan
- **Sequential fill:** after reset, drive words 0x00000000..0x0000001F with `out_ready` = 1. Expect `out_valid` for one cycle after the 32nd accept, `out_data` slot k = k, and `fill_cnt` back to 0.
- **Back-to-back rows:** stream 96 words continuously with `out_ready` = 1. Expect `in_ready` to stay 1 throughout and three rows on exactly every 32nd cycle, with slot contents matching the input order.
- **Backpressure:** hold `out_ready` = 0, send 64 words. Expect row 0 held stable, and `fill_cnt` = 32 with `in_ready` = 0 after word 64. Raise `out_ready` for one cycle: row 1 replaces row 0 with `out_valid` still 1, and `in_ready` = 1 on the next cycle.
- **Flush partial:** send 5 words 0xA0..0xA4 and pulse `in_flush` with the 5th. Expect slots 0..4 = 0xA0..0xA4, slots 5..31 = 0, and the next row starting at slot 0.
- **Flush ignored:** `in_flush` at `fill_cnt` = 0 produces no output. `in_flush` together with the 32nd word produces exactly one row.
- **Reset mid-row:** assert `rst` after 17 words with a row also pending. Expect `out_valid` = 0, `out_data` = 0, `fill_cnt` = 0, and the next 32 words forming a clean row.

Source files
------------

// File: rtl/demux32_row.sv
// -----------------------------------------------------------------------------
// demux32_row
//
// Row packer for the matrix-multiply datapath. Incoming words arrive one per
// accepted handshake and are placed, in arrival order, into the 32 slots of a
// row (slot k occupies bits [WIDTH*k +: WIDTH]). A completed row moves into
// an output register and is offered downstream on a second valid/ready
// handshake. The fill buffer and the output register are separate, so the
// next row keeps filling while the previous one waits for the consumer.
//
// Ports
//   clk        in   1             single clock, rising edge
//   rst        in   1             synchronous active-high reset
//   in_valid   in   1             input word valid
//   in_ready   out  1             input word accepted when in_valid && in_ready
//   in_data    in   WIDTH         input word
//   in_flush   in   1             close a partial row, unfilled slots read zero
//   out_valid  out  1             out_data holds a complete row
//   out_ready  in   1             consumer takes the row on out_valid && out_ready
//   out_data   out  32*WIDTH      row, slot k at [WIDTH*k +: WIDTH]
//   fill_cnt   out  6             words held in the fill buffer (0..32)
//
// fill_cnt == 32 marks a row that is complete (full or flushed) but could not
// move to the output register because the consumer had not taken the previous
// row. Input is refused in that state until the row has moved.
// -----------------------------------------------------------------------------
module demux32_row #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WIDTH-1:0]   out_data,
    output logic [5:0]            fill_cnt
);

    localparam int         SLOTS    = 32;
    localparam int         ROW_W    = SLOTS * WIDTH;
    localparam logic [5:0] CNT_LAST = 6'd31;
    localparam logic [5:0] CNT_FULL = 6'd32;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [ROW_W-1:0] fill_buf_q,  fill_buf_d;
    logic [5:0]       fill_cnt_q,  fill_cnt_d;
    logic [ROW_W-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;

    // -------------------------------------------------------------------------
    // Handshake and row-completion decode
    // -------------------------------------------------------------------------
    logic             stalled;     // complete row parked in the fill buffer
    logic             accept;      // input word taken this cycle
    logic             last_word;   // this accept fills slot 31
    logic [5:0]       cnt_after;   // fill count once this cycle's word is in
    logic             flush_take;  // flush request that actually closes a row
    logic             row_done;    // a complete row wants the output register
    logic             slot_free;   // output register can take a row this edge
    logic             pop;         // consumer takes the current output row
    logic [ROW_W-1:0] row_merged;  // fill buffer with this cycle's word merged

    assign stalled   = (fill_cnt_q == CNT_FULL);

    // Depends only on registered state and reset, never on in_valid/in_data,
    // so upstream can use it without forming a combinational loop.
    assign in_ready  = !rst && !stalled;

    assign accept    = in_valid && in_ready;
    assign last_word = accept && (fill_cnt_q == CNT_LAST);
    assign cnt_after = fill_cnt_q + {5'd0, accept};

    // A flush closes the row only if it would leave 1..31 words behind. An
    // empty row has nothing to emit, a stalled row is already closed, and a
    // flush alongside the 32nd word must not produce a second row.
    assign flush_take = in_flush && !stalled && !last_word && (cnt_after != 6'd0);

    assign row_done  = last_word || stalled || flush_take;
    assign slot_free = !out_valid_q || out_ready;
    assign pop       = out_valid_q && out_ready;

    // -------------------------------------------------------------------------
    // Slot write: the incoming word lands in slot fill_cnt[4:0]. The merged
    // row feeds both the fill buffer and, on the bypass path, the output
    // register directly, so a row closing with its last word costs no bubble.
    // Unwritten slots are already zero, which is what makes flush padding free.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic slot_we;
            assign slot_we = accept && (fill_cnt_q[4:0] == 5'(gi));
            assign row_merged[gi*WIDTH +: WIDTH] =
                slot_we ? in_data : fill_buf_q[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        fill_buf_d  = fill_buf_q;
        fill_cnt_d  = fill_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (row_done && slot_free) begin
            // Transfer. If the consumer pops on this same edge the new row
            // simply replaces the old one and out_valid stays high.
            out_data_d  = row_merged;
            out_valid_d = 1'b1;
            fill_buf_d  = '0;
            fill_cnt_d  = 6'd0;
        end else if (row_done) begin
            // Output still occupied: park the row. slot_free is false here,
            // so no pop can be happening on this edge.
            fill_buf_d  = row_merged;
            fill_cnt_d  = CNT_FULL;
        end else begin
            fill_buf_d  = row_merged;
            fill_cnt_d  = cnt_after;
            if (pop) begin
                out_valid_d = 1'b0;   // out_data keeps its last value
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_buf_q  <= '0;
            fill_cnt_q  <= 6'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fill_buf_q  <= fill_buf_d;
            fill_cnt_q  <= fill_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign fill_cnt  = fill_cnt_q;

endmodule

// File: tb/tb_demux32_row.sv
// -----------------------------------------------------------------------------
// tb_demux32_row
//
// Directed scenarios plus a randomized run for demux32_row. A behavioural
// reference model (queue of accepted words, a "row closed" flag and the
// presented row) runs alongside the DUT; directed tasks additionally build
// their expected rows from the stimulus they drive.
// -----------------------------------------------------------------------------
module tb_demux32_row;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_flush;
    logic          out_valid;
    logic          out_ready;
    logic [1023:0] out_data;
    logic [5:0]    fill_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux32_row dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fill_cnt  (fill_cnt)
    );

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [31:0] m_fill[$];     // words of the row being collected
    bit          m_closed;      // row complete but waiting for the output
    logic [31:0] m_out[32];     // row currently presented
    bit          m_out_v;

    always @(posedge clk) begin : model
        bit done;
        bit free;
        if (rst) begin
            m_fill.delete();
            m_closed = 0;
            for (int k = 0; k < 32; k++) m_out[k] = '0;
            m_out_v = 0;
        end else begin
            free = !m_out_v || out_ready;
            done = m_closed;
            if (!m_closed) begin
                if (in_valid) m_fill.push_back(in_data);
                if (m_fill.size() == 32) done = 1;
                else if (in_flush && m_fill.size() != 0) done = 1;
            end
            if (done && free) begin
                for (int k = 0; k < 32; k++)
                    m_out[k] = (k < m_fill.size()) ? m_fill[k] : 32'h0;
                m_out_v = 1;
                m_fill.delete();
                m_closed = 0;
            end else if (done) begin
                m_closed = 1;
            end else if (m_out_v && out_ready) begin
                m_out_v = 0;
            end
        end
    end

    function automatic logic [1023:0] m_row();
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[32*k +: 32] = m_out[k];
        return r;
    endfunction

    function automatic logic [5:0] m_cnt();
        return m_closed ? 6'd32 : 6'(m_fill.size());
    endfunction

    function automatic logic m_rdy();
        return !rst && !m_closed;
    endfunction

    // Index of the first differing slot, used only to keep FAIL lines short.
    function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
        for (int k = 0; k < 32; k++)
            if (a[32*k +: 32] !== b[32*k +: 32]) return k;
        return 0;
    endfunction

    // -------------------------------------------------------------------------
    // Stimulus helpers (drive only)
    // -------------------------------------------------------------------------
    task automatic setin(input logic v, input logic [31:0] d, input logic f, input logic r);
        in_valid  = v;
        in_data   = d;
        in_flush  = f;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        setin(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (fill_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_fill_cnt: got %0d expected 0", fill_cnt);
        end
        checks++;
        if (out_data !== 1024'h0) begin
            errors++; $display("FAIL reset_out_data: slot %0d got %h expected 0",
                               first_diff(out_data, '0), out_data[32*first_diff(out_data, '0) +: 32]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_sequential();
        logic [1023:0] exp;
        for (int i = 0; i < 32; i++) begin
            exp[32*i +: 32] = 32'(i);
            setin(1'b1, 32'(i), 1'b0, 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL seq_in_ready: word %0d got %b expected 1", i, in_ready);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL seq_out_valid: got %b expected 1", out_valid);
        end
        checks++;
        if (out_data !== exp) begin
            errors++; $display("FAIL seq_row: slot %0d got %h expected %h", first_diff(out_data, exp),
                               out_data[32*first_diff(out_data, exp) +: 32], exp[32*first_diff(out_data, exp) +: 32]);
        end
        checks++;
        if (fill_cnt !== 6'd0) begin
            errors++; $display("FAIL seq_fill_cnt: got %0d expected 0", fill_cnt);
        end
        setin(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL seq_pop: out_valid got %b expected 0", out_valid);
        end
        $display("test_sequential done");
    endtask

    task automatic test_back_to_back();
        logic [31:0]   w[96];
        logic [1023:0] exp;
        for (int i = 0; i < 96; i++) begin
            w[i] = $urandom;
            setin(1'b1, w[i], 1'b0, 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_in_ready: word %0d got %b expected 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== ((i % 32) == 31)) begin
                errors++; $display("FAIL b2b_out_valid: word %0d got %b expected %b", i, out_valid, (i % 32) == 31);
            end
            checks++;
            if (fill_cnt !== 6'((i + 1) % 32)) begin
                errors++; $display("FAIL b2b_fill_cnt: word %0d got %0d expected %0d", i, fill_cnt, (i + 1) % 32);
            end
            if ((i % 32) == 31) begin
                for (int k = 0; k < 32; k++) exp[32*k +: 32] = w[i - 31 + k];
                checks++;
                if (out_data !== exp) begin
                    errors++; $display("FAIL b2b_row: row %0d slot %0d got %h expected %h", i / 32,
                                       first_diff(out_data, exp), out_data[32*first_diff(out_data, exp) +: 32],
                                       exp[32*first_diff(out_data, exp) +: 32]);
                end
            end
        end
        setin(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        $display("test_back_to_back done");
    endtask

    task automatic test_backpressure();
        logic [31:0]   w[64];
        logic [1023:0] row0;
        logic [1023:0] row1;
        for (int i = 0; i < 64; i++) begin
            w[i] = $urandom;
            if (i < 32) row0[32*i +: 32] = w[i];
            else        row1[32*(i-32) +: 32] = w[i];
            setin(1'b1, w[i], 1'b0, 1'b0);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL bp_in_ready: word %0d got %b expected 1", i, in_ready);
            end
            tick();
            if (i >= 31) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== row0) begin
                    errors++; $display("FAIL bp_row0_hold: word %0d valid %b slot %0d got %h expected %h", i, out_valid,
                                       first_diff(out_data, row0), out_data[32*first_diff(out_data, row0) +: 32],
                                       row0[32*first_diff(out_data, row0) +: 32]);
                end
            end
        end
        checks++;
        if (fill_cnt !== 6'd32 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stall: fill_cnt %0d in_ready %b expected 32 and 0", fill_cnt, in_ready);
        end
        setin(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== row1) begin
            errors++; $display("FAIL bp_row1: valid %b slot %0d got %h expected %h", out_valid,
                               first_diff(out_data, row1), out_data[32*first_diff(out_data, row1) +: 32],
                               row1[32*first_diff(out_data, row1) +: 32]);
        end
        checks++;
        if (in_ready !== 1'b1 || fill_cnt !== 6'd0) begin
            errors++; $display("FAIL bp_recover: in_ready %b fill_cnt %0d expected 1 and 0", in_ready, fill_cnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_pop: out_valid got %b expected 0", out_valid);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_flush_partial();
        logic [1023:0] exp;
        exp = '0;
        for (int i = 0; i < 5; i++) begin
            exp[32*i +: 32] = 32'hA0 + 32'(i);
            setin(1'b1, 32'hA0 + 32'(i), (i == 4), 1'b1);
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            errors++; $display("FAIL flush_row: valid %b slot %0d got %h expected %h", out_valid,
                               first_diff(out_data, exp), out_data[32*first_diff(out_data, exp) +: 32],
                               exp[32*first_diff(out_data, exp) +: 32]);
        end
        checks++;
        if (fill_cnt !== 6'd0) begin
            errors++; $display("FAIL flush_fill_cnt: got %0d expected 0", fill_cnt);
        end
        setin(1'b1, 32'hB0, 1'b0, 1'b1);
        tick();
        checks++;
        if (fill_cnt !== 6'd1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_next_start: fill_cnt %0d valid %b expected 1 and 0", fill_cnt, out_valid);
        end
        setin(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        exp = '0;
        exp[31:0] = 32'hB0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            errors++; $display("FAIL flush_next_row: valid %b slot %0d got %h expected %h", out_valid,
                               first_diff(out_data, exp), out_data[32*first_diff(out_data, exp) +: 32],
                               exp[32*first_diff(out_data, exp) +: 32]);
        end
        setin(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        $display("test_flush_partial done");
    endtask

    task automatic test_flush_ignored();
        for (int i = 0; i < 2; i++) begin
            setin(1'b0, 32'h0, 1'b1, 1'b1);
            tick();
            checks++;
            if (out_valid !== 1'b0 || fill_cnt !== 6'd0) begin
                errors++; $display("FAIL flush_empty: valid %b fill_cnt %0d expected 0 and 0", out_valid, fill_cnt);
            end
        end
        for (int i = 0; i < 32; i++) begin
            setin(1'b1, $urandom, (i == 31), 1'b1);
            tick();
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL flush_full_row: out_valid got %b expected 1", out_valid);
        end
        setin(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b0 || fill_cnt !== 6'd0) begin
            errors++; $display("FAIL flush_full_once: valid %b fill_cnt %0d expected 0 and 0", out_valid, fill_cnt);
        end
        $display("test_flush_ignored done");
    endtask

    task automatic test_reset_mid_row();
        logic [1023:0] exp;
        for (int i = 0; i < 49; i++) begin
            setin(1'b1, $urandom, 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (fill_cnt !== 6'd17 || out_valid !== 1'b1) begin
            errors++; $display("FAIL rmid_setup: fill_cnt %0d valid %b expected 17 and 1", fill_cnt, out_valid);
        end
        rst = 1'b1;
        setin(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || fill_cnt !== 6'd0 || out_data !== 1024'h0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rmid_reset: valid %b fill_cnt %0d data_zero %b in_ready %b expected 0 0 1 0",
                               out_valid, fill_cnt, out_data == 1024'h0, in_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp[32*i +: 32] = $urandom;
            setin(1'b1, exp[32*i +: 32], 1'b0, 1'b1);
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            errors++; $display("FAIL rmid_clean_row: valid %b slot %0d got %h expected %h", out_valid,
                               first_diff(out_data, exp), out_data[32*first_diff(out_data, exp) +: 32],
                               exp[32*first_diff(out_data, exp) +: 32]);
        end
        setin(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        $display("test_reset_mid_row done");
    endtask

    task automatic test_random();
        int unsigned ready_pct;
        int          bad;
        for (int c = 0; c < 3000; c++) begin
            ready_pct = (c < 1000) ? 90 : ((c < 2000) ? 30 : 60);
            setin(($urandom_range(99) < 80), $urandom, ($urandom_range(99) < 8),
                  ($urandom_range(99) < ready_pct));
            bad = 0;
            checks++;
            if (in_ready !== m_rdy()) begin
                errors++; bad++;
                $display("FAIL rand_in_ready: cycle %0d got %b expected %b", c, in_ready, m_rdy());
            end
            tick();
            checks++;
            if (out_valid !== m_out_v) begin
                errors++; bad++;
                $display("FAIL rand_out_valid: cycle %0d got %b expected %b", c, out_valid, m_out_v);
            end
            checks++;
            if (fill_cnt !== m_cnt()) begin
                errors++; bad++;
                $display("FAIL rand_fill_cnt: cycle %0d got %0d expected %0d", c, fill_cnt, m_cnt());
            end
            checks++;
            if (out_data !== m_row()) begin
                errors++; bad++;
                $display("FAIL rand_out_data: cycle %0d slot %0d got %h expected %h", c,
                         first_diff(out_data, m_row()), out_data[32*first_diff(out_data, m_row()) +: 32],
                         m_out[first_diff(out_data, m_row())]);
            end
            if (bad > 0 && errors > 40) break;
        end
        $display("test_random done");
    endtask

    initial begin
        rst = 1'b1;
        setin(1'b0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_sequential();
        test_back_to_back();
        test_backpressure();
        test_flush_partial();
        test_flush_ignored();
        test_reset_mid_row();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
